// File: rtl/mmio_timer_if.sv
// MMIO bus interface shared by the register blocks at 0xFF00-0xFFFF.
interface mem_if;
  logic [15:0] addr_select;
  logic        write_enable;
  logic [7:0]  write_value;
  logic [7:0]  read_out;

  modport slave (
    input  addr_select,
    input  write_enable,
    input  write_value,
    output read_out
  );

  modport master (
    output addr_select,
    output write_enable,
    output write_value,
    input  read_out
  );
endinterface

// File: rtl/mmio_timer.sv
// Game Boy DIV/TIMA/TMA/TAC timer at 0xFF04-0xFF07, one clk per T-cycle.
// Define MMIO_TIMER_GLITCH_EN to reproduce DMG spurious increments on DIV/TAC writes.
module mmio_timer (
  input  logic  clk,
  input  logic  rst,
  mem_if.slave  req,
  output logic  timer_irq
);

  localparam logic [1:0] StRun    = 2'd0;
  localparam logic [1:0] StDelay  = 2'd1;
  localparam logic [1:0] StReload = 2'd2;

  logic [15:0] sys_cnt_q, sys_cnt_d;
  logic [7:0]  tima_q, tima_d;
  logic [7:0]  tma_q, tma_d;
  logic [2:0]  tac_q, tac_d;
  logic [1:0]  state_q, state_d;
  logic [1:0]  dcnt_q, dcnt_d;
  logic        tick_q, tick_d;
  logic        irq_q, irq_d;
  logic [2:0]  hold_q [4];
  logic [3:0]  sel;
  logic [3:0]  commit;
  logic        tick_in;
  logic        fall;

  function automatic logic tap_bit(input logic [15:0] cnt, input logic [2:0] tac);
    logic b;
    unique case (tac[1:0])
      2'd0: b = cnt[9];
      2'd1: b = cnt[3];
      2'd2: b = cnt[5];
      2'd3: b = cnt[7];
    endcase
    return b & tac[2];
  endfunction

  // Index 0..3 maps to FF04..FF07; a write commits on the second edge of its assertion.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      sel[i]    = req.write_enable && (req.addr_select[15:2] == 14'h3FC1) &&
                  (req.addr_select[1:0] == 2'(i));
      commit[i] = sel[i] && (hold_q[i] == 3'd1);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst || !sel[i]) begin
        hold_q[i] <= '0;
      end else if (hold_q[i] != 3'd7) begin
        hold_q[i] <= hold_q[i] + 3'd1;
      end
    end
  end

  assign tick_in = tap_bit(sys_cnt_q, tac_q);
  assign fall    = tick_q & ~tick_in;

  always_comb begin
    sys_cnt_d = commit[0] ? 16'h0000 : sys_cnt_q + 16'h0001;
    tma_d     = commit[2] ? req.write_value : tma_q;
    tac_d     = commit[3] ? req.write_value[2:0] : tac_q;
`ifdef MMIO_TIMER_GLITCH_EN
    tick_d    = tick_in;
`else
    // Resync the edge detector so DIV/TAC writes cannot fake a falling edge.
    tick_d    = (commit[0] || commit[3]) ? tap_bit(sys_cnt_d, tac_d) : tick_in;
`endif

    tima_d  = tima_q;
    state_d = state_q;
    dcnt_d  = dcnt_q;
    irq_d   = 1'b0;
    unique case (state_q)
      StDelay: begin
        if (commit[1]) begin
          tima_d  = req.write_value;
          state_d = StRun;
        end else begin
          dcnt_d = dcnt_q + 2'd1;
          if (dcnt_q == 2'd2) state_d = StReload;
        end
      end
      StReload: begin
        // Reload wins over a same-edge TIMA write but sees a same-edge TMA write.
        tima_d  = tma_d;
        irq_d   = 1'b1;
        state_d = StRun;
      end
      default: begin
        if (commit[1]) begin
          tima_d = req.write_value;
        end else if (fall) begin
          if (tima_q == 8'hFF) begin
            tima_d  = 8'h00;
            dcnt_d  = 2'd0;
            state_d = StDelay;
          end else begin
            tima_d = tima_q + 8'h01;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sys_cnt_q <= '0;
      tima_q    <= '0;
      tma_q     <= '0;
      tac_q     <= '0;
      state_q   <= StRun;
      dcnt_q    <= '0;
      tick_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      sys_cnt_q <= sys_cnt_d;
      tima_q    <= tima_d;
      tma_q     <= tma_d;
      tac_q     <= tac_d;
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      tick_q    <= tick_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    case (req.addr_select)
      16'hFF04: req.read_out = sys_cnt_q[15:8];
      16'hFF05: req.read_out = tima_q;
      16'hFF06: req.read_out = tma_q;
      16'hFF07: req.read_out = {5'b11111, tac_q};
      default:  req.read_out = 8'haa;
    endcase
  end

  assign timer_irq = irq_q;

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: directed scenarios plus random bus traffic
// compared every cycle against a countdown-based behavioural model.
module tb_mmio_timer;

`ifdef MMIO_TIMER_GLITCH_EN
  localparam bit Glitch = 1'b1;
`else
  localparam bit Glitch = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic timer_irq;
  mem_if bus ();

  mmio_timer dut (
    .clk       (clk),
    .rst       (rst),
    .req       (bus),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int irq_count = 0;
  logic [7:0] last_rd;
  logic       last_irq;

  // Reference model state; m_cd counts edges remaining until the reload (0 = idle).
  bit          m_valid = 1'b0;
  int unsigned m_sys;
  logic [7:0]  m_tima, m_tma;
  logic [2:0]  m_tac;
  bit          m_prev, m_irq;
  int          m_cd;
  logic [15:0] m_last_addr;
  int          m_streak;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%02h exp=%02h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_tick(input int unsigned s, input logic [2:0] t);
    int unsigned b;
    case (t[1:0])
      2'd0:    b = 9;
      2'd1:    b = 3;
      2'd2:    b = 5;
      default: b = 7;
    endcase
    return t[2] && (((s >> b) & 1) == 1);
  endfunction

  function automatic logic [7:0] m_read(input logic [15:0] a);
    case (a)
      16'hFF04: return 8'(m_sys >> 8);
      16'hFF05: return m_tima;
      16'hFF06: return m_tma;
      16'hFF07: return {5'b11111, m_tac};
      default:  return 8'haa;
    endcase
  endfunction

  task automatic model_step(input bit r, input bit we, input logic [15:0] a,
                            input logic [7:0] v);
    bit tick_now, fall, commit, c_div, c_tima, c_tma, c_tac, irq_next;
    int unsigned new_sys;
    logic [7:0] new_tma;
    logic [2:0] new_tac;
    if (r) begin
      m_valid = 1'b1; m_sys = 0; m_tima = 0; m_tma = 0; m_tac = 0;
      m_prev = 0; m_irq = 0; m_cd = 0; m_streak = 0; m_last_addr = 0;
      return;
    end
    tick_now = m_tick(m_sys, m_tac);
    fall     = m_prev && !tick_now;
    commit   = 1'b0;
    if (we) begin
      if (m_streak > 0 && a == m_last_addr) begin
        commit = (m_streak == 1);
        m_streak++;
      end else begin
        m_streak    = 1;
        m_last_addr = a;
      end
    end else begin
      m_streak = 0;
    end
    c_div  = commit && a == 16'hFF04;
    c_tima = commit && a == 16'hFF05;
    c_tma  = commit && a == 16'hFF06;
    c_tac  = commit && a == 16'hFF07;
    new_sys = c_div ? 0 : (m_sys + 1) % 65536;
    new_tma = c_tma ? v : m_tma;
    new_tac = c_tac ? v[2:0] : m_tac;
    irq_next = 1'b0;
    if (m_cd > 0) begin
      if (m_cd == 1) begin
        m_tima = new_tma; irq_next = 1'b1; m_cd = 0;
      end else if (c_tima) begin
        m_tima = v; m_cd = 0;
      end else begin
        m_cd--;
      end
    end else if (c_tima) begin
      m_tima = v;
    end else if (fall) begin
      if (m_tima == 8'hFF) begin
        m_tima = 8'h00; m_cd = 4;
      end else begin
        m_tima = m_tima + 8'h01;
      end
    end
    if (Glitch || !(c_div || c_tac)) m_prev = tick_now;
    else m_prev = m_tick(new_sys, new_tac);
    m_sys = new_sys; m_tma = new_tma; m_tac = new_tac; m_irq = irq_next;
  endtask

  // One clock: drive, sample at negedge against the model, then advance the model.
  task automatic cycle(input bit r, input bit we, input logic [15:0] a, input logic [7:0] v);
    rst = r;
    bus.write_enable = we;
    bus.addr_select  = a;
    bus.write_value  = v;
    @(negedge clk);
    last_rd  = bus.read_out;
    last_irq = timer_irq;
    if (last_irq === 1'b1) irq_count++;
    if (m_valid) begin
      chk("model_rd", last_rd, m_read(a));
      chk("model_irq", {7'b0, last_irq}, {7'b0, m_irq});
    end
    @(posedge clk);
    model_step(r, we, a, v);
    #1;
  endtask

  task automatic idle(input int n, input logic [15:0] a);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, a, 8'h00);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] v, input int len,
                    input logic [15:0] rd_a);
    for (int i = 0; i < len; i++) cycle(1'b0, 1'b1, a, v);
    cycle(1'b0, 1'b0, rd_a, 8'h00);
  endtask

  task automatic wait_ovf(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      cycle(1'b0, 1'b0, 16'hFF05, 8'h00);
      if (m_cd == 4) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, {7'b0, ok}, 8'h01);
  endtask

  task automatic setup_ovf;
    cycle(1'b1, 1'b0, 16'hFF05, 8'h00);
    wr(16'hFF06, 8'h80, 2, 16'hFF06);
    wr(16'hFF05, 8'hFE, 2, 16'hFF05);
    wr(16'hFF07, 8'h05, 2, 16'hFF07);
  endtask

  initial begin
    int unsigned op;
    int          zeros;
    bit          found;
    logic [15:0] a;
    logic [7:0]  v;
    logic [7:0]  vals [5];

    // Reset state and free-running DIV.
    cycle(1'b1, 1'b0, 16'hFF04, 8'h00);
    irq_count = 0;
    idle(256, 16'hFF04);
    cycle(1'b0, 1'b0, 16'hFF04, 8'h00); chk("div_after_256", last_rd, 8'h01);
    cycle(1'b0, 1'b0, 16'hFF05, 8'h00); chk("tima_reset", last_rd, 8'h00);
    cycle(1'b0, 1'b0, 16'hFF07, 8'h00); chk("tac_reset", last_rd, 8'hF8);
    cycle(1'b0, 1'b0, 16'hFF08, 8'h00); chk("unmapped", last_rd, 8'haa);
    chk("no_irq_idle", 8'(irq_count), 8'h00);

    // Overflow: four zero reads, then TMA with a single irq cycle.
    setup_ovf();
    zeros = 0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cycle(1'b0, 1'b0, 16'hFF05, 8'h00);
      if (last_irq === 1'b1) begin
        found = 1'b1;
        break;
      end
      if (last_rd == 8'h00) zeros++;
    end
    chk("ovf_irq_seen", {7'b0, found}, 8'h01);
    chk("ovf_reload_val", last_rd, 8'h80);
    chk("ovf_zero_cycles", 8'(zeros), 8'h04);
    cycle(1'b0, 1'b0, 16'hFF05, 8'h00);
    chk("irq_one_cycle", {7'b0, last_irq}, 8'h00);

    // TIMA write during the delay cancels the reload.
    setup_ovf();
    wait_ovf("ovf_seen_cancel");
    wr(16'hFF05, 8'h42, 2, 16'hFF05);
    chk("cancel_val", last_rd, 8'h42);
    irq_count = 0;
    idle(8, 16'hFF06);
    chk("cancel_no_irq", 8'(irq_count), 8'h00);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 1'b0, 16'hFF05, 8'h00);
      if (last_rd != 8'h42) break;
    end
    chk("cancel_next_inc", last_rd, 8'h43);

    // TMA write committed on the reload edge is used by the reload.
    setup_ovf();
    wait_ovf("ovf_seen_tma");
    idle(2, 16'hFF05);
    wr(16'hFF06, 8'h33, 2, 16'hFF05);
    chk("reload_new_tma", last_rd, 8'h33);
    chk("reload_tma_irq", {7'b0, last_irq}, 8'h01);

    // TIMA write committed on the reload edge is discarded.
    setup_ovf();
    wait_ovf("ovf_seen_tima");
    idle(2, 16'hFF05);
    wr(16'hFF05, 8'h77, 2, 16'hFF05);
    chk("reload_beats_write", last_rd, 8'h80);
    chk("reload_wr_irq", {7'b0, last_irq}, 8'h01);

    // DIV write while the tap bit is high.
    cycle(1'b1, 1'b0, 16'hFF05, 8'h00);
    wr(16'hFF07, 8'h04, 2, 16'hFF07);
    found = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      cycle(1'b0, 1'b0, 16'hFF05, 8'h00);
      if (((m_sys >> 9) & 1) == 1 && (m_sys & 32'h1FF) < 32'h100) begin
        found = 1'b1;
        break;
      end
    end
    chk("tap9_reached", {7'b0, found}, 8'h01);
    wr(16'hFF04, 8'h5A, 2, 16'hFF05);
    cycle(1'b0, 1'b0, 16'hFF05, 8'h00);
    chk("div_write_tima", last_rd, Glitch ? 8'h01 : 8'h00);
    cycle(1'b0, 1'b0, 16'hFF04, 8'h00);
    chk("div_write_div", last_rd, 8'h00);

    // Long write: only the value at the second edge lands; then reset mid-delay.
    cycle(1'b1, 1'b0, 16'hFF05, 8'h00);
    for (int i = 0; i < 5; i++) begin
      vals[i] = 8'($urandom);
      cycle(1'b0, 1'b1, 16'hFF06, vals[i]);
    end
    cycle(1'b0, 1'b0, 16'hFF06, 8'h00);
    chk("long_write_tma", last_rd, vals[1]);
    wr(16'hFF05, 8'hFE, 2, 16'hFF05);
    wr(16'hFF07, 8'h05, 2, 16'hFF07);
    wait_ovf("ovf_seen_rst");
    idle(1, 16'hFF05);
    cycle(1'b1, 1'b0, 16'hFF05, 8'h00);
    irq_count = 0;
    cycle(1'b0, 1'b0, 16'hFF04, 8'h00); chk("rst_div", last_rd, 8'h00);
    cycle(1'b0, 1'b0, 16'hFF05, 8'h00); chk("rst_tima", last_rd, 8'h00);
    cycle(1'b0, 1'b0, 16'hFF06, 8'h00); chk("rst_tma", last_rd, 8'h00);
    cycle(1'b0, 1'b0, 16'hFF07, 8'h00); chk("rst_tac", last_rd, 8'hF8);
    idle(10, 16'hFF05);
    chk("rst_no_irq", 8'(irq_count), 8'h00);

    // Random traffic against the model.
    for (int k = 0; k < 800; k++) begin
      op = $urandom_range(0, 39);
      a  = 16'hFF04 + 16'($urandom_range(0, 4));
      v  = 8'($urandom);
      if (op == 0) begin
        cycle(1'b1, 1'b0, a, v);
      end else if (op < 16) begin
        if (a == 16'hFF04 && $urandom_range(0, 3) != 0) a = 16'hFF05;
        if (a == 16'hFF05 && $urandom_range(0, 1) == 1) v = 8'hFC + 8'($urandom_range(0, 3));
        if (a == 16'hFF07 && $urandom_range(0, 3) != 0) v[2] = 1'b1;
        wr(a, v, $urandom_range(1, 4), 16'hFF04 + 16'($urandom_range(0, 4)));
      end else if (op < 19) begin
        for (int i = 0; i < 3; i++)
          cycle(1'b0, 1'b1, 16'hFF04 + 16'($urandom_range(0, 4)), 8'($urandom));
      end else begin
        idle($urandom_range(1, 12), a);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_timer.md
# mmio_timer

Game Boy DIV/TIMA/TMA/TAC timer on the MMIO bus at 0xFF04–0xFF07. It sits directly upstream of the interrupt-register block and drives that block's timer interrupt line with a one-cycle pulse, which the interrupt block ORs into IF[2]. It is clocked at the T-cycle rate (4.194304 MHz), so one clk equals one T-cycle.

## Interface
- No parameters.
- clk  input  1  system clock, T-cycle rate.
- rst  input  1  reset, synchronous, active-high.
- req  mem_if.slave  —  MMIO bus; uses addr_select[15:0], write_enable, write_value[7:0], read_out[7:0].
- timer_irq  output  1  one-cycle pulse on TIMA reload after overflow.

## Operation
- Internal 16-bit counter `sys_cnt` increments by 1 every clk and wraps at 0xFFFF→0x0000.
- DIV = sys_cnt[15:8].
- TAC[2] = enable. TAC[1:0] selects the tap bit:
  - 00 → bit 9 (4096 Hz)
  - 01 → bit 3 (262144 Hz)
  - 10 → bit 5 (65536 Hz)
  - 11 → bit 7 (16384 Hz)
- Increment signal `tick_in` = sys_cnt[tap] & TAC[2]. It is registered each cycle, and TIMA increments on every falling edge (prev 1, current 0).
- Read mux (combinational):
  - FF04 → DIV
  - FF05 → TIMA
  - FF06 → TMA
  - FF07 → {5'b11111, TAC}
  - any other address → 8'haa
- Write commit: a write commits on the clk edge at which write_enable, with the address held constant, has already been high for exactly one prior cycle. This is the second edge of the assertion.
  - A per-address 3-bit hold counter tracks the assertion and clears when write_enable is low or the address changes.
  - One commit per assertion, regardless of its length.
- Writes:
  - FF04, any value: sys_cnt ← 0.
  - FF05: TIMA ← value.
  - FF06: TMA ← value.
  - FF07: TAC ← value[2:0].
- Overflow FSM, states RUN, DELAY, RELOAD:
  - RUN: an increment of TIMA=0xFF sets TIMA ← 0x00, starts delay count = 0, and moves to DELAY.
  - DELAY: lasts 3 cycles with TIMA reading 0x00. A TIMA write committed in DELAY cancels the reload: TIMA ← written value, no irq, back to RUN. Falling-edge increments during DELAY are ignored.
  - RELOAD: on the 4th edge after overflow, TIMA ← TMA, timer_irq = 1 for exactly that cycle, then RUN.
    - A TIMA write committed on the same edge is discarded (the reload wins).
    - A TMA write committed on the same edge is used by the reload (TIMA gets the new TMA).
- Simultaneous TIMA write and increment in RUN: the write wins and the increment is lost.
- Reset: sys_cnt = 0, TIMA = 0, TMA = 0, TAC = 0, FSM = RUN, hold counters = 0, edge register = 0, timer_irq = 0. Reset mid-DELAY aborts the overflow with no irq.

## Timing
- Overflow edge E: TIMA = 0x00 after E.
- Edges E+1 to E+3: TIMA reads 0x00.
- Edge E+4: TIMA = TMA and timer_irq high from E+4 to E+5.
- read_out has zero latency: it reflects register state in the same cycle.
- DIV-write effect: sys_cnt = 0 after the commit edge and 1 after the next edge.
- Increment latency: TIMA changes on the edge after the edge at which sys_cnt[tap] falls.
- timer_irq is registered and never high for more than one cycle per overflow.

## Configuration
- `MMIO_TIMER_GLITCH_EN` defined:
  - A DIV reset that clears a tap bit at 1 produces a TIMA increment, as does a TAC write that changes tap or enable while `tick_in` is 1.
  - This matches DMG hardware.
- Undefined: on any DIV or TAC commit, the edge register is reloaded with the post-write `tick_in`, so those writes never cause an increment.

## Test plan
- Reset, then run 256 clk → DIV reads 0x01, TIMA 0x00, FF07 reads 0xF8, unmapped FF08 reads 0xaa, timer_irq never high.
- TAC=0x05, TMA=0x80, TIMA=0xFE → after the 2nd tap falling edge, TIMA reads 0x00 for 4 cycles, then 0x80 with timer_irq high for exactly 1 cycle.
- Same setup, write TIMA=0x42 committed on edge E+2 → TIMA = 0x42, no timer_irq, next increment gives 0x43.
- Same setup, TMA=0x33 committed on edge E+4 and a TIMA write on E+4 → TIMA = 0x33, irq pulse present.
- TAC=0x04, wait until sys_cnt[9]=1, write DIV → TIMA +1 with `MMIO_TIMER_GLITCH_EN`, unchanged without it. DIV reads 0x00 afterward in both cases.
- Hold write_enable at FF06 for 5 cycles with the value changing each cycle → TMA equals the value present at the 2nd edge only. Then assert rst during DELAY → all registers 0, no irq.
